timer_irq_ctrl: RTL and testbench

//  Interrupt controller that schedules IRQs from up to N_SRC timer (TC) instances and other sources onto the CPU's single interrupt line.
//  - Captures rising edges of each source into a pending register.
//  - Arbitrates among pending & masked-in sources (fixed or round-robin).
//  - Presents one request plus vector to the CPU under a req/ack handshake.
//  - Holds that source in-service until software writes EOI.
//  - Sits on the same word-addressed peripheral bus as the timers.

---
 rtl/timer_irq_ctrl_pkg.sv | 21 ++
 rtl/irq_rr_arb.sv | 39 +++
 rtl/timer_irq_ctrl.sv | 121 ++++++++++++
 tb/tb_timer_irq_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/timer_irq_ctrl_pkg.sv
// Shared types and constants for the timer interrupt controller.
//   state_t        : request FSM states
//   REG_*          : register index decoded from Addr[3:2]
//   CTRL_EN/RR     : bit positions inside CTRL
package timer_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_ISR  = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_RR = 1;

endpackage

// File: rtl/irq_rr_arb.sv
// Purely combinational winner picker.
//   eligible : candidate sources
//   rr_ptr   : search start when rr_en = 1
//   rr_en    : 1 = round-robin from rr_ptr, 0 = fixed (lowest id wins)
//   any      : at least one eligible source
//   winner   : selected source id (0 when none)
module irq_rr_arb #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [ID_W-1:0]  rr_ptr,
  input  logic             rr_en,
  output logic             any,
  output logic [ID_W-1:0]  winner
);

  always_comb begin
    int          base;
    int          j;
    logic        found;
    logic [ID_W-1:0] jj;
    any    = |eligible;
    winner = '0;
    found  = 1'b0;
    // Fixed priority is just a round-robin scan starting at 0.
    base   = rr_en ? int'(rr_ptr) : 0;
    for (int k = 0; k < N_SRC; k++) begin
      j = base + k;
      if (j >= N_SRC) j = j - N_SRC;
      jj = ID_W'(j);
      if (!found && eligible[jj]) begin
        found  = 1'b1;
        winner = jj;
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interrupt controller merging N_SRC level sources onto one CPU request line.
//   clk, reset : clock, async active-low reset
//   Addr/WE/Din/Dout : word-addressed register bus; Addr[1:0] here is byte
//                      address bits [3:2] (CTRL, MASK, PEND, ISR)
//   src_irq    : level interrupt inputs, rising edges latched into PEND
//   cpu_irq    : registered request; cpu_ack accepts it
//   cpu_vec    : id of the requested / in-service source
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [29:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] src_irq,
  output logic             cpu_irq,
  input  logic             cpu_ack,
  output logic [ID_W-1:0]  cpu_vec
);

  state_t           state;
  logic             ctrl_en, ctrl_rr, isr_valid;
  logic [N_SRC-1:0] mask, pend, prev_src, pend_clr, eligible;
  logic [ID_W-1:0]  rr_ptr, winner;
  logic             any;
  logic [1:0]       idx;
  logic             ctrl_wr, mask_wr, pend_wr, eoi;
  logic             unused_ok;

  assign idx       = Addr[1:0];
  assign ctrl_wr   = WE && (idx == REG_CTRL);
  assign mask_wr   = WE && (idx == REG_MASK);
  assign pend_wr   = WE && (idx == REG_PEND);
  assign eoi       = WE && (idx == REG_ISR);
  assign eligible  = pend & mask & {N_SRC{ctrl_en}};
  assign unused_ok = ^{Addr[29:2], Din};

  irq_rr_arb #(.N_SRC(N_SRC), .ID_W(ID_W)) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .rr_en    (ctrl_rr),
    .any      (any),
    .winner   (winner)
  );

  // Bits cleared this cycle by W1C or by the CPU accepting the request.
  always_comb begin
    pend_clr = '0;
    if (pend_wr) pend_clr = Din[N_SRC-1:0];
    if (state == REQ && cpu_ack) pend_clr[cpu_vec] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_rr   <= 1'b0;
      mask      <= '0;
      pend      <= '0;
      prev_src  <= '0;
      isr_valid <= 1'b0;
      rr_ptr    <= '0;
      cpu_irq   <= 1'b0;
      cpu_vec   <= '0;
    end else begin
      prev_src <= src_irq;
      // New edge is OR'd in after the clear so a same-cycle set wins.
      pend     <= (pend & ~pend_clr) | (src_irq & ~prev_src);
      if (ctrl_wr) begin
        ctrl_en <= Din[CTRL_EN];
        ctrl_rr <= Din[CTRL_RR];
      end
      if (mask_wr) mask <= Din[N_SRC-1:0];

      case (state)
        IDLE: if (any) begin
          cpu_vec <= winner;
          cpu_irq <= 1'b1;
          state   <= REQ;
        end
        REQ: begin
          if (cpu_ack) begin
            isr_valid <= 1'b1;
            rr_ptr    <= (cpu_vec == ID_W'(N_SRC - 1)) ? '0 : cpu_vec + 1'b1;
            cpu_irq   <= 1'b0;
            state     <= SERVICE;
          end else if (!eligible[cpu_vec]) begin
            // Source went away before the CPU took it: withdraw, re-arbitrate.
            cpu_irq <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVICE: if (eoi) begin
          isr_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          cpu_irq <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (idx)
      REG_CTRL: Dout = {30'd0, ctrl_rr, ctrl_en};
      REG_MASK: Dout = 32'(mask);
      REG_PEND: Dout = 32'(pend);
      REG_ISR:  Dout = isr_valid ? (32'h8000_0000 | 32'(cpu_vec)) : 32'd0;
      default:  Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [7:0]  src_irq;
  logic        cpu_irq;
  logic        cpu_ack;
  logic [2:0]  cpu_vec;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] C = 2'd0, M = 2'd1, P = 2'd2, I = 2'd3;

  typedef struct {
    logic        we;
    logic [1:0]  idx;
    logic [31:0] din;
    logic [7:0]  src;
    logic        ack;
    logic        eirq;
    logic [2:0]  evec;
    logic [31:0] edout;
  } vec_t;

  vec_t tv[$];

  timer_irq_ctrl #(.N_SRC(8)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout),
    .src_irq(src_irq), .cpu_irq(cpu_irq), .cpu_ack(cpu_ack), .cpu_vec(cpu_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, return 1 time unit after posedge.
  task automatic step(input logic we, input logic [1:0] idx, input logic [31:0] din,
                      input logic [7:0] src, input logic ack);
    @(negedge clk);
    WE = we; Addr = {28'd0, idx}; Din = din; src_irq = src; cpu_ack = ack;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t V(input logic we, input logic [1:0] idx, input logic [31:0] din,
                             input logic [7:0] src, input logic ack, input logic eirq,
                             input logic [2:0] evec, input logic [31:0] edout);
    vec_t v;
    v = '{we, idx, din, src, ack, eirq, evec, edout};
    return v;
  endfunction

  initial begin
    reset = 1'b0; Addr = '0; WE = 1'b0; Din = '0; src_irq = '0; cpu_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst irq", 32'(cpu_irq), 32'd0);
    chk("rst vec", 32'(cpu_vec), 32'd0);
    for (int r = 0; r < 4; r++) begin
      Addr = 30'(r); #1;
      chk($sformatf("rst reg%0d", r), Dout, 32'd0);
    end
    @(negedge clk); reset = 1'b1;

    // basic flow, fixed priority, round-robin
    tv.push_back(V(1, M, 32'h3,  8'h00, 0, 0, 0, 32'h3));
    tv.push_back(V(1, C, 32'h1,  8'h00, 0, 0, 0, 32'h1));
    tv.push_back(V(0, P, 0,      8'h02, 0, 0, 0, 32'h2));
    tv.push_back(V(0, P, 0,      8'h00, 0, 1, 1, 32'h2));
    tv.push_back(V(0, I, 0,      8'h00, 1, 0, 1, 32'h8000_0001));
    tv.push_back(V(0, P, 0,      8'h00, 0, 0, 1, 32'h0));
    tv.push_back(V(1, I, 0,      8'h00, 0, 0, 1, 32'h0));
    tv.push_back(V(1, M, 32'hFF, 8'h00, 0, 0, 1, 32'hFF));
    tv.push_back(V(0, P, 0,      8'h24, 0, 0, 1, 32'h24));
    tv.push_back(V(0, P, 0,      8'h24, 0, 1, 2, 32'h24));
    tv.push_back(V(0, I, 0,      8'h24, 1, 0, 2, 32'h8000_0002));
    tv.push_back(V(1, I, 0,      8'h00, 0, 0, 2, 32'h0));
    tv.push_back(V(0, P, 0,      8'h00, 0, 1, 5, 32'h20));
    tv.push_back(V(0, I, 0,      8'h00, 1, 0, 5, 32'h8000_0005));
    tv.push_back(V(1, I, 0,      8'h00, 0, 0, 5, 32'h0));
    tv.push_back(V(1, C, 32'h3,  8'h01, 0, 0, 5, 32'h3));
    tv.push_back(V(0, P, 0,      8'h00, 0, 1, 0, 32'h1));
    tv.push_back(V(0, I, 0,      8'h00, 1, 0, 0, 32'h8000_0000));
    tv.push_back(V(0, P, 0,      8'h09, 0, 0, 0, 32'h9));
    tv.push_back(V(1, I, 0,      8'h09, 0, 0, 0, 32'h0));
    tv.push_back(V(0, P, 0,      8'h00, 0, 1, 3, 32'h9));
    tv.push_back(V(0, I, 0,      8'h00, 1, 0, 3, 32'h8000_0003));
    tv.push_back(V(1, I, 0,      8'h00, 0, 0, 3, 32'h0));
    tv.push_back(V(0, P, 0,      8'h00, 0, 1, 0, 32'h1));
    tv.push_back(V(0, I, 0,      8'h00, 1, 0, 0, 32'h8000_0000));
    tv.push_back(V(1, I, 0,      8'h00, 0, 0, 0, 32'h0));
    tv.push_back(V(0, P, 0,      8'h80, 0, 0, 0, 32'h80));
    tv.push_back(V(0, P, 0,      8'h00, 0, 1, 7, 32'h80));
    tv.push_back(V(0, I, 0,      8'h00, 1, 0, 7, 32'h8000_0007));
    tv.push_back(V(0, P, 0,      8'h41, 0, 0, 7, 32'h41));
    tv.push_back(V(1, I, 0,      8'h00, 0, 0, 7, 32'h0));
    tv.push_back(V(0, P, 0,      8'h00, 0, 1, 0, 32'h41));
    tv.push_back(V(0, I, 0,      8'h00, 1, 0, 0, 32'h8000_0000));
    tv.push_back(V(1, I, 0,      8'h00, 0, 0, 0, 32'h0));
    tv.push_back(V(0, P, 0,      8'h00, 0, 1, 6, 32'h40));
    tv.push_back(V(0, I, 0,      8'h00, 1, 0, 6, 32'h8000_0006));
    tv.push_back(V(1, I, 0,      8'h00, 0, 0, 6, 32'h0));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].we, tv[i].idx, tv[i].din, tv[i].src, tv[i].ack);
      chk($sformatf("v%0d irq", i),  32'(cpu_irq), 32'(tv[i].eirq));
      chk($sformatf("v%0d vec", i),  32'(cpu_vec), 32'(tv[i].evec));
      chk($sformatf("v%0d dout", i), Dout, tv[i].edout);
    end

    // withdraw on mask, then re-request with same vector
    step(1, C, 32'h1,  8'h00, 0);
    step(0, P, 0,      8'h10, 0);
    step(0, P, 0,      8'h00, 0);
    chk("wd req irq", 32'(cpu_irq), 32'd1);
    chk("wd req vec", 32'(cpu_vec), 32'd4);
    step(1, M, 32'h0,  8'h00, 0);
    chk("wd hold irq", 32'(cpu_irq), 32'd1);
    step(0, P, 0,      8'h00, 0);
    chk("wd drop irq", 32'(cpu_irq), 32'd0);
    chk("wd pend", Dout, 32'h10);
    step(1, M, 32'h10, 8'h00, 0);
    chk("wd idle irq", 32'(cpu_irq), 32'd0);
    step(0, P, 0,      8'h00, 0);
    chk("wd rereq irq", 32'(cpu_irq), 32'd1);
    chk("wd rereq vec", 32'(cpu_vec), 32'd4);
    step(0, I, 0,      8'h00, 1);
    chk("wd isr", Dout, 32'h8000_0004);
    step(1, I, 0,      8'h00, 0);

    // level held across service, then W1C racing a new rise
    step(1, M, 32'hFF, 8'h04, 0);
    step(0, P, 0,      8'h04, 0);
    chk("lvl req vec", 32'(cpu_vec), 32'd2);
    step(0, P, 0,      8'h04, 1);
    chk("lvl pend ack", Dout, 32'h0);
    step(0, P, 0,      8'h04, 0);
    chk("lvl pend svc", Dout, 32'h0);
    step(1, I, 0,      8'h04, 0);
    step(0, P, 0,      8'h04, 0);
    chk("lvl no rereq", 32'(cpu_irq), 32'd0);
    chk("lvl pend held", Dout, 32'h0);
    step(0, P, 0,      8'h00, 0);
    step(1, P, 32'h04, 8'h04, 0);
    chk("w1c race pend", Dout, 32'h4);
    step(0, P, 0,      8'h04, 0);
    chk("w1c race irq", 32'(cpu_irq), 32'd1);
    chk("w1c race vec", 32'(cpu_vec), 32'd2);
    step(0, P, 0,      8'h00, 1);
    step(1, I, 0,      8'h00, 0);

    // async reset mid-REQ
    step(0, P, 0,      8'h02, 0);
    step(0, P, 0,      8'h00, 0);
    chk("ar req irq", 32'(cpu_irq), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar irq", 32'(cpu_irq), 32'd0);
    chk("ar vec", 32'(cpu_vec), 32'd0);
    for (int r = 0; r < 4; r++) begin
      Addr = 30'(r); #1;
      chk($sformatf("ar reg%0d", r), Dout, 32'd0);
    end
    @(negedge clk); reset = 1'b1;
    step(0, P, 0,      8'h00, 0);
    chk("ar post irq", 32'(cpu_irq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
